// File: rtl/int_sequencer.sv
// Interrupt sequencer: synchronizes/edge-detects irq_in, drains fetch/decode, injects one vector cycle, tracks the handler until RETI.
// Optional overrun counter enabled by defining INT_SEQ_OVERRUN_CNT_EN.
module int_sequencer #(
  parameter logic [9:0] VECTOR       = 10'h3FF,
  parameter int         SYNC_STAGES  = 2,
  parameter int         DRAIN_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       irq_in,
  input  logic       i_flag,
  input  logic       branch_busy,
  input  logic       mem_stall,
  input  logic       reti_ex,
  output logic       flush,
  output logic       fetch_hold,
  output logic       vector_sel,
  output logic [9:0] vector_addr,
  output logic       int_take,
  output logic       int_active,
  output logic       pending,
  output logic [7:0] overrun_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_VECTOR  = 2'd2,
    ST_SERVICE = 2'd3
  } state_t;

  localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

  state_t                 state_reg, state_next;
  logic [3:0]             drain_cnt_reg, drain_cnt_next;
  logic                   pending_reg, pending_next;
  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   prev_reg;
  logic                   irq_edge;

  // Synchronizer chain; stage 0 samples the asynchronous pin.
  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        always_ff @(posedge clk or posedge rst) begin
          if (rst) sync_reg[gi] <= 1'b0;
          else     sync_reg[gi] <= irq_in;
        end
      end else begin : g_rest
        always_ff @(posedge clk or posedge rst) begin
          if (rst) sync_reg[gi] <= 1'b0;
          else     sync_reg[gi] <= sync_reg[gi-1];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) prev_reg <= 1'b0;
    else     prev_reg <= sync_reg[SYNC_STAGES-1];
  end

  assign irq_edge = sync_reg[SYNC_STAGES-1] & ~prev_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      drain_cnt_reg <= 4'd0;
      pending_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      drain_cnt_reg <= drain_cnt_next;
      pending_reg   <= pending_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    drain_cnt_next = drain_cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        drain_cnt_next = 4'd0;
        if (pending_reg && i_flag) state_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (drain_cnt_reg != DRAIN_LAST) drain_cnt_next = drain_cnt_reg + 4'd1;
        if (drain_cnt_reg == DRAIN_LAST && !branch_busy && !mem_stall)
          state_next = ST_VECTOR;
      end
      ST_VECTOR:  state_next = ST_SERVICE;
      ST_SERVICE: if (reti_ex) state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase
  end

  // A new edge wins over the clear issued by the vector cycle.
  always_comb begin
    pending_next = pending_reg;
    if (state_reg == ST_VECTOR) pending_next = 1'b0;
    if (irq_edge)               pending_next = 1'b1;
  end

  always_comb begin
    flush      = 1'b0;
    fetch_hold = 1'b0;
    vector_sel = 1'b0;
    int_take   = 1'b0;
    int_active = 1'b0;
    case (state_reg)
      ST_DRAIN: begin
        flush      = 1'b1;
        fetch_hold = 1'b1;
      end
      ST_VECTOR: begin
        flush      = 1'b1;
        vector_sel = 1'b1;
        int_take   = 1'b1;
      end
      ST_SERVICE: int_active = 1'b1;
      default: ;
    endcase
  end

  assign vector_addr = VECTOR;
  assign pending     = pending_reg;

`ifdef INT_SEQ_OVERRUN_CNT_EN
  logic [7:0] overrun_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      overrun_cnt_reg <= 8'h00;
    else if (irq_edge && pending_reg && overrun_cnt_reg != 8'hFF)
      overrun_cnt_reg <= overrun_cnt_reg + 8'd1;
  end

  assign overrun_cnt = overrun_cnt_reg;
`else
  assign overrun_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_int_sequencer.sv
// Self-checking bench for int_sequencer: expected int_take cycles are queued when stimulus is driven
// and popped by a monitor when the pulse appears.
module tb_int_sequencer;

  localparam int SYNC = 2;
  localparam int DRN  = 2;
  localparam int TAKE_LAT = SYNC + 1 + DRN + 1;  // drive negedge -> negedge showing int_take

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       irq_in = 1'b0;
  logic       i_flag = 1'b0;
  logic       branch_busy = 1'b0;
  logic       mem_stall = 1'b0;
  logic       reti_ex = 1'b0;
  logic       flush, fetch_hold, vector_sel, int_take, int_active, pending;
  logic [9:0] vector_addr;
  logic [7:0] overrun_cnt;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int exp_q[$];
  logic prev_take = 1'b0;

  int_sequencer #(.VECTOR(10'h3FF), .SYNC_STAGES(SYNC), .DRAIN_CYCLES(DRN)) dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .i_flag(i_flag),
    .branch_busy(branch_busy), .mem_stall(mem_stall), .reti_ex(reti_ex),
    .flush(flush), .fetch_hold(fetch_hold), .vector_sel(vector_sel),
    .vector_addr(vector_addr), .int_take(int_take), .int_active(int_active),
    .pending(pending), .overrun_cnt(overrun_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: each int_take pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (int_take) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("[TB] FAIL unexpected_take: int_take=1 at cycle %0d, required no pulse", cyc);
      end else begin
        int e;
        e = exp_q.pop_front();
        if (cyc !== e) begin
          fails++;
          $display("[TB] FAIL take_cycle: got cycle %0d, required %0d", cyc, e);
        end else
          $display("[TB] int_take at cycle %0d as expected", cyc);
      end
      tests++;
      if (vector_sel !== 1'b1 || flush !== 1'b1 || prev_take !== 1'b0) begin
        fails++;
        $display("[TB] FAIL take_shape: vector_sel=%b flush=%b prev_take=%b, required 1 1 0",
                 vector_sel, flush, prev_take);
      end
    end
    prev_take <= int_take;
  end

  initial begin
    #500000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_q(input int budget);
    int k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      tick(1);
      k++;
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("[TB] FAIL take_missing: %0d pulses outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reti;
    reti_ex = 1'b1;
    tick(1);
    reti_ex = 1'b0;
    tests++;
    if (int_active !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reti_exit: int_active=%b, required 0", int_active);
    end
    $display("[TB] reti at cycle %0d", cyc);
  endtask

  task automatic test_reset;
    tick(3);
    tests++;
    if ({flush, fetch_hold, vector_sel, int_take, int_active, pending} !== 6'b0 ||
        overrun_cnt !== 8'h00 || vector_addr !== 10'h3FF) begin
      fails++;
      $display("[TB] FAIL reset_state: ctl=%b ovr=%h vec=%h, required 000000 00 3ff",
               {flush, fetch_hold, vector_sel, int_take, int_active, pending}, overrun_cnt, vector_addr);
    end
    rst = 1'b0;
    tick(2);
    $display("[TB] reset released at cycle %0d", cyc);
  endtask

  task automatic test_basic;
    int n;
    logic [3:0] got, want;
    i_flag = 1'b1;
    n = cyc;
    irq_in = 1'b1;
    exp_q.push_back(n + TAKE_LAT);
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      want = {(k >= 4 && k <= 6), (k == 4 || k == 5), (k == 6), (k >= 7)};
      got  = {flush, fetch_hold, vector_sel, int_active};
      tests++;
      if (got !== want) begin
        fails++;
        $display("[TB] FAIL basic_seq k=%0d: flush/hold/vsel/active=%b, required %b", k, got, want);
      end
    end
    irq_in = 1'b0;
    wait_q(2);
    tick(2);
    do_reti;
  endtask

  task automatic test_masked;
    int m;
    i_flag = 1'b0;
    irq_in = 1'b1;
    tick(4);
    irq_in = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick(1);
      tests++;
      if (pending !== 1'b1 || flush !== 1'b0) begin
        fails++;
        $display("[TB] FAIL masked_idle k=%0d: pending=%b flush=%b, required 1 0", k, pending, flush);
      end
    end
    m = cyc;
    i_flag = 1'b1;
    exp_q.push_back(m + 3);
    tick(1);
    tests++;
    if (flush !== 1'b1 || fetch_hold !== 1'b1) begin
      fails++;
      $display("[TB] FAIL masked_drain: flush=%b hold=%b, required 1 1", flush, fetch_hold);
    end
    wait_q(8);
    tick(1);
    do_reti;
  endtask

  task automatic test_drain_ext;
    int n;
    i_flag = 1'b1;
    n = cyc;
    irq_in = 1'b1;
    tick(4);
    branch_busy = 1'b1;
    tick(4);
    branch_busy = 1'b0;
    exp_q.push_back(n + 9);
    tests++;
    if (flush !== 1'b1 || int_take !== 1'b0) begin
      fails++;
      $display("[TB] FAIL drain_hold: flush=%b int_take=%b, required 1 0", flush, int_take);
    end
    wait_q(6);
    tick(1);
    tests++;
    if (int_take !== 1'b0 || int_active !== 1'b1) begin
      fails++;
      $display("[TB] FAIL drain_after: int_take=%b int_active=%b, required 0 1", int_take, int_active);
    end
    irq_in = 1'b0;
    do_reti;
  endtask

  task automatic test_overrun;
    logic [7:0] exp1, exp2;
`ifdef INT_SEQ_OVERRUN_CNT_EN
    exp1 = 8'd1;
    exp2 = 8'd2;
`else
    exp1 = 8'd0;
    exp2 = 8'd0;
`endif
    i_flag = 1'b0;
    irq_in = 1'b1; tick(3);
    irq_in = 1'b0; tick(3);
    irq_in = 1'b1; tick(4);
    tests++;
    if (overrun_cnt !== exp1 || pending !== 1'b1) begin
      fails++;
      $display("[TB] FAIL overrun_1: ovr=%0d pending=%b, required %0d 1", overrun_cnt, pending, exp1);
    end
    irq_in = 1'b0; tick(3);
    irq_in = 1'b1; tick(4);
    tests++;
    if (overrun_cnt !== exp2) begin
      fails++;
      $display("[TB] FAIL overrun_2: ovr=%0d, required %0d", overrun_cnt, exp2);
    end
    irq_in = 1'b0;
    i_flag = 1'b1;
    exp_q.push_back(cyc + 3);
    wait_q(8);
    tick(1);
    do_reti;
    $display("[TB] overrun count now %0d", overrun_cnt);
  endtask

  task automatic test_reti_race;
    int n;
    i_flag = 1'b1;
    n = cyc;
    irq_in = 1'b1;
    exp_q.push_back(n + TAKE_LAT);
    tick(3);
    irq_in = 1'b0;
    tick(5);
    tests++;
    if (int_active !== 1'b1) begin
      fails++;
      $display("[TB] FAIL race_service: int_active=%b, required 1", int_active);
    end
    n = cyc;
    irq_in = 1'b1;
    exp_q.push_back(n + 6);
    tick(2);
    reti_ex = 1'b1;
    tick(1);
    reti_ex = 1'b0;
    tests++;
    if (pending !== 1'b1 || int_active !== 1'b0 || flush !== 1'b0) begin
      fails++;
      $display("[TB] FAIL race_idle: pending=%b active=%b flush=%b, required 1 0 0",
               pending, int_active, flush);
    end
    wait_q(8);
    tick(1);
    irq_in = 1'b0;
    do_reti;
  endtask

  task automatic test_async_reset;
    i_flag = 1'b1;
    irq_in = 1'b1;
    tick(4);
    tests++;
    if (flush !== 1'b1 || fetch_hold !== 1'b1) begin
      fails++;
      $display("[TB] FAIL areset_pre: flush=%b hold=%b, required 1 1", flush, fetch_hold);
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if (flush !== 1'b0 || fetch_hold !== 1'b0 || pending !== 1'b0) begin
      fails++;
      $display("[TB] FAIL areset_async: flush=%b hold=%b pending=%b, required 0 0 0",
               flush, fetch_hold, pending);
    end
    irq_in = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(1);
    tests++;
    if (pending !== 1'b0) begin
      fails++;
      $display("[TB] FAIL areset_pending: pending=%b, required 0", pending);
    end
    tick(12);
    tests++;
    if (int_active !== 1'b0 || overrun_cnt !== 8'h00) begin
      fails++;
      $display("[TB] FAIL areset_after: active=%b ovr=%0d, required 0 0", int_active, overrun_cnt);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_masked;
    test_drain_ext;
    test_overrun;
    test_reti_race;
    test_async_reset;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/int_sequencer.md
# int_sequencer

Interrupt sequencer for the pipelined RAT CPU.
- Synchronizes and edge-detects the external interrupt line, holds it pending until the I flag permits it, and drains the fetch/decode stages.
- Injects a single vector-fetch cycle, then tracks the service routine until RETI retires.
- Sits beside the hazard controller: its flush/hold outputs are OR-ed into the decode NOP and fetch-stall paths; its vector outputs drive the ROM address mux and the decoder INT input.

## Interface
Parameters:
- VECTOR, 10'h3FF, interrupt vector ROM address driven on vector_addr
- SYNC_STAGES, 2, flops in irq_in synchronizer (legal 2..4)
- DRAIN_CYCLES, 2, minimum cycles of flush before vector injection (legal 1..15)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- irq_in  in  1  external interrupt request, asynchronous, rising-edge significant
- i_flag  in  1  current I flag (interrupts enabled)
- branch_busy  in  1  branch/call/ret in execute or PC load pending
- mem_stall  in  1  instruction memory stall from hazard controller
- reti_ex  in  1  RETID/RETIE in execute stage this cycle
- flush  out  1  force decode NOP
- fetch_hold  out  1  hold fetch register and PC
- vector_sel  out  1  select vector_addr onto ROM address
- vector_addr  out  10  constant VECTOR
- int_take  out  1  one-cycle pulse to decoder INT (push PC, clear I, shadow flags)
- int_active  out  1  handler in progress
- pending  out  1  latched, not-yet-serviced request
- overrun_cnt  out  8  requests lost while already pending

## Operation
- Synchronizer: SYNC_STAGES flops, then a prev flop; edge = sync_last & ~prev.
- pending: set on edge; cleared in VECTOR. One-deep only; set has priority over clear in the same cycle.
- States: IDLE, DRAIN, VECTOR, SERVICE (Moore outputs).
- IDLE: all controls 0. Go to DRAIN when pending && i_flag.
- DRAIN:
  - flush=1, fetch_hold=1.
  - 4-bit drain_cnt is cleared on entry, increments each cycle, and saturates at DRAIN_CYCLES-1.
  - Go to VECTOR when drain_cnt==DRAIN_CYCLES-1 && !branch_busy && !mem_stall; otherwise stay.
  - i_flag is not rechecked in DRAIN.
- VECTOR: vector_sel=1, int_take=1, flush=1, exactly one cycle; pending cleared; go to SERVICE.
- SERVICE: int_active=1; other controls 0. Go to IDLE on reti_ex.
- Edge while pending already 1 (any state): overrun_cnt += 1, saturating at 8'hFF.
- reti_ex outside SERVICE: ignored.
- vector_addr is always VECTOR, regardless of state.

## Timing
- Reset (async assert, sync-to-clock deassert by system): state=IDLE, pending=0, drain_cnt=0, sync/prev flops=0, overrun_cnt=0. All outputs 0 except vector_addr=VECTOR.
- Reset asserted mid-DRAIN/VECTOR/SERVICE: immediate return to IDLE; the request is discarded.
- Latency with SYNC_STAGES=2, DRAIN_CYCLES=2, i_flag=1, no stalls, irq_in rising before edge 0:
  - sync at edges 0/1; pending=1 after edge 2; DRAIN after edge 3.
  - VECTOR after edge 5; SERVICE after edge 6.
  - General VECTOR edge = SYNC_STAGES+1+DRAIN_CYCLES.
- pending with i_flag=0: stays in IDLE indefinitely; taken one cycle after i_flag rises.
- reti_ex and edge in same SERVICE cycle: IDLE next with pending=1; re-entry gated by i_flag (RETIE restores it).
- irq_in held high: one request only; a new request needs a low period of at least 1 synchronized cycle.

## Configuration
- INT_SEQ_OVERRUN_CNT_EN defined: overrun counter implemented as above.
- Not defined: no counter flops; overrun_cnt tied to 8'h00. All other behaviour is identical.

## Test plan
- Basic take: rst pulse, i_flag=1, irq_in 0→1 at cycle 10 → int_take single pulse at edge 15 (defaults), vector_sel=1 in the same cycle, flush high for 3 cycles, int_active=1 afterwards.
- Masked: i_flag=0, irq edge → pending=1, state stays IDLE 20 cycles; raise i_flag → DRAIN next cycle, int_take 3 cycles later.
- Drain extension: branch_busy=1 for 4 cycles during DRAIN → VECTOR delayed until the cycle after branch_busy falls; int_take still one cycle wide.
- Overrun: two irq edges 6 cycles apart before service, then a third → overrun_cnt=1 then 2 with the macro defined; stays 0 without it.
- RETI race: in SERVICE, irq edge coincident with reti_ex, i_flag=1 → IDLE, pending=1, second int_take 4 cycles later.
- Async reset mid-DRAIN: assert rst between edges → flush/fetch_hold drop without waiting for the clock; pending=0 after release; no int_take.
